sym_tick_gen: RTL and testbench

- Parametrised successor to the game's clock divider. Generates three single-cycle tick strobes from Clk100M: display refresh, 1 Hz level timer, and symbol move/generate.
- The symbol rate is level-programmable, with a saturating floor.
- The symbol and seconds timebases can be restarted on game-period changes.
- Sits between the top-level clock input and the game FSM, symbol generator and 7-segment driver.

---
 rtl/sym_clk_pkg.sv | 40 ++++
 rtl/sym_tick_gen_tick_div.sv | 54 +++++
 rtl/sym_tick_gen.sv | 128 ++++++++++++
 tb/tb_sym_tick_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sym_clk_pkg.sv
// -----------------------------------------------------------------------------
// sym_clk_pkg
// Shared constants and helpers for the game tick generator.
//   CNT_W_DEF          default counter / divisor width
//   *_DIV_DEF          default divisors in Clk100M cycles (100 MHz board clock)
//   SYM_STEP_DEF       symbol period reduction per game level
//   sym_div_calc()     saturating level -> symbol divisor mapping
// -----------------------------------------------------------------------------
package sym_clk_pkg;

    localparam int unsigned CNT_W_DEF        = 32;
    localparam int unsigned DISP_DIV_DEF     = 500000;
    localparam int unsigned SEC_DIV_DEF      = 100000000;
    localparam int unsigned SYM_BASE_DIV_DEF = 100000000;
    localparam int unsigned SYM_STEP_DEF     = 5000000;
    localparam int unsigned SYM_MIN_DIV_DEF  = 10000000;

    // Width of the divisor arithmetic. As long as CNT_W + LEVEL_W fits in
    // 64 bits the product can never wrap, so the result equals the
    // CNT_W+LEVEL_W-bit computation.
    localparam int unsigned CALC_W = 64;

    // Symbol period shrinks by step per level but never drops below min_div.
    // The comparison is done before the subtraction so a large level
    // saturates instead of wrapping around to a huge period.
    function automatic logic [CALC_W-1:0] sym_div_calc(
        input logic [CALC_W-1:0] level,
        input logic [CALC_W-1:0] base_div,
        input logic [CALC_W-1:0] step,
        input logic [CALC_W-1:0] min_div
    );
        logic [CALC_W-1:0] product;
        product = level * step;
        if (product > (base_div - min_div)) begin
            return min_div;
        end
        return base_div - product;
    endfunction

endpackage

// File: rtl/sym_tick_gen_tick_div.sv
// -----------------------------------------------------------------------------
// tick_div
// One divider channel: counts 0..div-1 and emits a registered one-cycle tick
// during the cycle after the terminal count.
//   Clk100M  system clock
//   reset    synchronous active-high reset
//   clr      restart the period (counter and tick cleared this edge)
//   en       count enable; when low the counter is held at 0
//   div      period in clock cycles (>= 2)
//   tick     one-cycle strobe, once per div cycles
// -----------------------------------------------------------------------------
module tick_div #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             Clk100M,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Restart beats terminal count, so a clear on the last count of a period
    // swallows that tick. The >= guards against a counter left above a
    // freshly lowered divisor, although the clear-on-load normally prevents it.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q >= (div - CNT_W'(1))) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/sym_tick_gen.sv
// -----------------------------------------------------------------------------
// sym_tick_gen
// Generates the game's timebase strobes from the 100 MHz clock.
//   Clk100M      system clock
//   reset        synchronous active-high reset
//   level        current game level (unsigned)
//   level_load   strobe: reload symbol divisor from level, restart symbol period
//   sec_restart  strobe: restart the 1 Hz timebase
//   sym_en       symbol ticks enabled (game period active)
//   ClkDisp      display refresh tick, one cycle per DISP_DIV
//   Clk1Hz       seconds tick, one cycle per SEC_DIV
//   ClkSymGen    symbol move/generate tick, one cycle per sym_div
//   sym_div      current symbol divisor
// Optional (macro SYM_TICK_SQUARE_EN):
//   ClkDispSq    square wave toggling on every ClkDisp tick
//   Clk1HzSq     square wave toggling on every Clk1Hz tick, cleared by sec_restart
// -----------------------------------------------------------------------------
module sym_tick_gen
    import sym_clk_pkg::*;
#(
    parameter int unsigned DISP_DIV     = DISP_DIV_DEF,
    parameter int unsigned SEC_DIV      = SEC_DIV_DEF,
    parameter int unsigned SYM_BASE_DIV = SYM_BASE_DIV_DEF,
    parameter int unsigned SYM_STEP     = SYM_STEP_DEF,
    parameter int unsigned SYM_MIN_DIV  = SYM_MIN_DIV_DEF,
    parameter int unsigned LEVEL_W      = 4,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic               Clk100M,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level,
    input  logic               level_load,
    input  logic               sec_restart,
    input  logic               sym_en,
    output logic               ClkDisp,
    output logic               Clk1Hz,
    output logic               ClkSymGen,
    output logic [CNT_W-1:0]   sym_div
`ifdef SYM_TICK_SQUARE_EN
    ,
    output logic               ClkDispSq,
    output logic               Clk1HzSq
`endif
);

    logic [CNT_W-1:0] sym_div_q, sym_div_d;
    logic             disp_tick, sec_tick, sym_tick;

    // New symbol divisor is latched on level_load; the symbol channel is
    // cleared on the same edge so the new period starts cleanly.
    always_comb begin
        sym_div_d = sym_div_q;
        if (level_load) begin
            sym_div_d = CNT_W'(sym_div_calc(CALC_W'(level),
                                            CALC_W'(SYM_BASE_DIV),
                                            CALC_W'(SYM_STEP),
                                            CALC_W'(SYM_MIN_DIV)));
        end
    end

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            sym_div_q <= CNT_W'(SYM_BASE_DIV);
        end else begin
            sym_div_q <= sym_div_d;
        end
    end

    tick_div #(.CNT_W(CNT_W)) u_disp_div (
        .Clk100M (Clk100M),
        .reset   (reset),
        .clr     (1'b0),
        .en      (1'b1),
        .div     (CNT_W'(DISP_DIV)),
        .tick    (disp_tick)
    );

    tick_div #(.CNT_W(CNT_W)) u_sec_div (
        .Clk100M (Clk100M),
        .reset   (reset),
        .clr     (sec_restart),
        .en      (1'b1),
        .div     (CNT_W'(SEC_DIV)),
        .tick    (sec_tick)
    );

    tick_div #(.CNT_W(CNT_W)) u_sym_div (
        .Clk100M (Clk100M),
        .reset   (reset),
        .clr     (level_load),
        .en      (sym_en),
        .div     (sym_div_q),
        .tick    (sym_tick)
    );

    assign ClkDisp   = disp_tick;
    assign Clk1Hz    = sec_tick;
    assign ClkSymGen = sym_tick;
    assign sym_div   = sym_div_q;

`ifdef SYM_TICK_SQUARE_EN
    logic disp_sq_q, disp_sq_d;
    logic sec_sq_q, sec_sq_d;

    // Each square output flips on the cycle its tick is high, giving a
    // 50% duty wave at half the tick rate.
    always_comb begin
        disp_sq_d = disp_sq_q ^ disp_tick;
        sec_sq_d  = sec_restart ? 1'b0 : (sec_sq_q ^ sec_tick);
    end

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            disp_sq_q <= 1'b0;
            sec_sq_q  <= 1'b0;
        end else begin
            disp_sq_q <= disp_sq_d;
            sec_sq_q  <= sec_sq_d;
        end
    end

    assign ClkDispSq = disp_sq_q;
    assign Clk1HzSq  = sec_sq_q;
`else
    // Square-wave outputs are not built; only the tick strobes exist.
`endif

endmodule

// File: tb/tb_sym_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_sym_tick_gen
// Self-checking bench for sym_tick_gen with small divisors
// (DISP 5, SEC 10, SYM base 20, step 4, min 6). A cycle model pushes the
// expected outputs for every clock edge into a queue; a negedge monitor pops
// and compares them against the DUT. Set SYM_TICK_SQUARE_EN to also check
// the square-wave outputs.
// -----------------------------------------------------------------------------
module tb_sym_tick_gen;

    localparam int DISP_DIV = 5;
    localparam int SEC_DIV  = 10;
    localparam int SYM_BASE = 20;
    localparam int SYM_STEP = 4;
    localparam int SYM_MIN  = 6;

    logic        Clk100M;
    logic        reset;
    logic [3:0]  level;
    logic        level_load;
    logic        sec_restart;
    logic        sym_en;
    logic        ClkDisp;
    logic        Clk1Hz;
    logic        ClkSymGen;
    logic [31:0] sym_div;
`ifdef SYM_TICK_SQUARE_EN
    logic        ClkDispSq;
    logic        Clk1HzSq;
`endif

    typedef struct {
        int   cyc;
        logic disp;
        logic sec;
        logic sym;
        int   div;
        logic dsq;
        logic ssq;
    } exp_t;

    exp_t exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: cycles elapsed since each channel last restarted.
    int   cyc_n   = 0;
    int   disp_n  = 0;
    int   sec_n   = 0;
    int   sym_n   = 0;
    int   m_div   = SYM_BASE;
    logic m_disp  = 1'b0;
    logic m_sec   = 1'b0;
    logic m_sym   = 1'b0;
    logic m_dsq   = 1'b0;
    logic m_ssq   = 1'b0;
    logic [3:0] cur_level = 4'd0;

    sym_tick_gen #(
        .DISP_DIV     (DISP_DIV),
        .SEC_DIV      (SEC_DIV),
        .SYM_BASE_DIV (SYM_BASE),
        .SYM_STEP     (SYM_STEP),
        .SYM_MIN_DIV  (SYM_MIN),
        .LEVEL_W      (4),
        .CNT_W        (32)
    ) dut (
        .Clk100M     (Clk100M),
        .reset       (reset),
        .level       (level),
        .level_load  (level_load),
        .sec_restart (sec_restart),
        .sym_en      (sym_en),
        .ClkDisp     (ClkDisp),
        .Clk1Hz      (Clk1Hz),
        .ClkSymGen   (ClkSymGen),
        .sym_div     (sym_div)
`ifdef SYM_TICK_SQUARE_EN
        ,
        .ClkDispSq   (ClkDispSq),
        .Clk1HzSq    (Clk1HzSq)
`endif
    );

    initial Clk100M = 1'b0;
    always #5 Clk100M = ~Clk100M;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int expDiv(input int lvl);
        int product;
        product = lvl * SYM_STEP;
        if (product > SYM_BASE - SYM_MIN) return SYM_MIN;
        return SYM_BASE - product;
    endfunction

    // Advance the model by one clock edge using the inputs that were applied.
    task automatic modelStep();
        cyc_n++;
        if (reset) begin
            disp_n = 0; sec_n = 0; sym_n = 0; m_div = SYM_BASE;
            m_disp = 1'b0; m_sec = 1'b0; m_sym = 1'b0;
            m_dsq = 1'b0; m_ssq = 1'b0;
        end else begin
            m_dsq = m_dsq ^ m_disp;
            m_ssq = sec_restart ? 1'b0 : (m_ssq ^ m_sec);
            disp_n++;
            m_disp = (disp_n % DISP_DIV) == 0;
            if (sec_restart) begin
                sec_n = 0;
                m_sec = 1'b0;
            end else begin
                sec_n++;
                m_sec = (sec_n % SEC_DIV) == 0;
            end
            if (level_load) m_div = expDiv(int'(level));
            if (level_load || !sym_en) begin
                sym_n = 0;
                m_sym = 1'b0;
            end else begin
                sym_n++;
                m_sym = (sym_n % m_div) == 0;
            end
        end
        exp_q.push_back('{cyc_n, m_disp, m_sec, m_sym, m_div, m_dsq, m_ssq});
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] lvl, input logic load,
                                 input logic restart, input logic en);
        @(negedge Clk100M);
        reset       = rst;
        level       = lvl;
        level_load  = load;
        sec_restart = restart;
        sym_en      = en;
        @(posedge Clk100M);
        modelStep();
    endtask

    task automatic runCycles(input int n, input logic en);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, cur_level, 1'b0, 1'b0, en);
    endtask

    task automatic loadLevel(input logic [3:0] lvl, input logic en);
        cur_level = lvl;
        applyStimulus(1'b0, lvl, 1'b1, 1'b0, en);
    endtask

    always @(negedge Clk100M) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput($sformatf("ClkDisp@%0d", e.cyc), ClkDisp, e.disp);
            checkOutput($sformatf("Clk1Hz@%0d", e.cyc), Clk1Hz, e.sec);
            checkOutput($sformatf("ClkSymGen@%0d", e.cyc), ClkSymGen, e.sym);
            checkOutput($sformatf("sym_div@%0d", e.cyc), sym_div, e.div);
`ifdef SYM_TICK_SQUARE_EN
            checkOutput($sformatf("ClkDispSq@%0d", e.cyc), ClkDispSq, e.dsq);
            checkOutput($sformatf("Clk1HzSq@%0d", e.cyc), Clk1HzSq, e.ssq);
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        reset       = 1'b1;
        level       = 4'd0;
        level_load  = 1'b0;
        sec_restart = 1'b0;
        sym_en      = 1'b1;

        $display("[TB] reset and free run");
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        runCycles(60, 1'b1);

        $display("[TB] level loads and saturation");
        runCycles(6, 1'b1);
        loadLevel(4'd2, 1'b1);
        runCycles(30, 1'b1);
        loadLevel(4'd9, 1'b1);
        runCycles(20, 1'b1);
        loadLevel(4'd15, 1'b1);
        runCycles(15, 1'b1);
        loadLevel(4'd3, 1'b1);
        runCycles(12, 1'b1);

        $display("[TB] seconds restart on terminal count");
        for (int i = 0; i < 12 && (sec_n % SEC_DIV) != SEC_DIV - 1; i++) runCycles(1, 1'b1);
        applyStimulus(1'b0, cur_level, 1'b0, 1'b1, 1'b1);
        runCycles(15, 1'b1);
        applyStimulus(1'b0, 4'd1, 1'b1, 1'b1, 1'b1);
        cur_level = 4'd1;
        runCycles(20, 1'b1);

        $display("[TB] symbol enable gating");
        runCycles(20, 1'b0);
        loadLevel(4'd4, 1'b0);
        runCycles(30, 1'b0);
        runCycles(12, 1'b1);

        $display("[TB] reset mid-count");
        runCycles(3, 1'b1);
        applyStimulus(1'b1, cur_level, 1'b0, 1'b0, 1'b1);
        runCycles(25, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 120; i++) begin
            logic [3:0] lvl;
            logic       load, restart, en;
            lvl     = 4'($urandom_range(0, 15));
            load    = ($urandom_range(0, 15) == 0);
            restart = ($urandom_range(0, 19) == 0);
            en      = ($urandom_range(0, 9) != 0);
            if (load) cur_level = lvl;
            applyStimulus(1'b0, lvl, load, restart, en);
        end
        applyStimulus(1'b0, cur_level, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge Clk100M);
        if (exp_q.size() > 0) checkOutput("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
